mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_ctrl_pkg.sv | 118 +++++++++++
 rtl/mc_ctrl_if.sv | 47 ++++
 rtl/mc_ctrl_decode.sv | 144 ++++++++++++++
 rtl/mc_control_fsm.sv | 157 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle controller and its datapath:
//   - controller state encoding (state_e)
//   - opcode constants of the supported instruction subset
//   - ALU_SrcB, ALU_op and PC_source encodings
//   - op-class encoding latched by the controller in DECODE (op_class_e)
//   - ctrl_t, the bundle of control outputs produced by the decoder
//   - classify(), mapping an opcode onto its op-class
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_MEM_ADDR = 4'd3,
      ST_MEM_RD   = 4'd4,
      ST_MEM_WB   = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_R_EX     = 4'd7,
      ST_R_WB     = 4'd8,
      ST_I_EX     = 4'd9,
      ST_I_WB     = 4'd10,
      ST_BRANCH   = 4'd11,
      ST_JUMP     = 4'd12,
      ST_HALT     = 4'd13
   } state_e;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operand B select
   localparam logic [2:0] SRCB_RT     = 3'd0;
   localparam logic [2:0] SRCB_FOUR   = 3'd1;
   localparam logic [2:0] SRCB_IMM    = 3'd2;
   localparam logic [2:0] SRCB_OFFSET = 3'd3;
   localparam logic [2:0] SRCB_UPPER  = 3'd4;

   // ALU operation
   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_FUNCT = 3'd2;
   localparam logic [2:0] ALU_AND   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_SLT   = 3'd5;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

   typedef enum logic [3:0] {
      OPC_NONE    = 4'd0,
      OPC_LW      = 4'd1,
      OPC_SW      = 4'd2,
      OPC_RTYPE   = 4'd3,
      OPC_ADDI    = 4'd4,
      OPC_ANDI    = 4'd5,
      OPC_ORI     = 4'd6,
      OPC_SLTI    = 4'd7,
      OPC_LUI     = 4'd8,
      OPC_BEQ     = 4'd9,
      OPC_BNE     = 4'd10,
      OPC_JUMP    = 4'd11,
      OPC_ILLEGAL = 4'd12
   } op_class_e;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [2:0] alu_src_b;
      logic       ex_top;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = 19'd0;

   // Map an opcode onto the op-class carried forward from DECODE.
   function automatic op_class_e classify(input logic [5:0] opcode);
      op_class_e cls;
      case (opcode)
         OP_LW:    cls = OPC_LW;
         OP_SW:    cls = OPC_SW;
         OP_RTYPE: cls = OPC_RTYPE;
         OP_ADDI:  cls = OPC_ADDI;
         OP_ANDI:  cls = OPC_ANDI;
         OP_ORI:   cls = OPC_ORI;
         OP_SLTI:  cls = OPC_SLTI;
         OP_LUI:   cls = OPC_LUI;
         OP_BEQ:   cls = OPC_BEQ;
         OP_BNE:   cls = OPC_BNE;
         OP_J:     cls = OPC_JUMP;
         default:  cls = OPC_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_if
// Control bus between the multi-cycle controller and its datapath.
//   Status into the controller : Opcode[5:0], Funct[5:0], Zero, Mem_ready
//   Controls out of controller : Mem_req, Mem_write, IorD, IR_write, PC_write,
//                                Reg_write, Reg_dst, Mem_to_reg, ALU_SrcA,
//                                ALU_SrcB[2:0], Ex_top, ALU_op[2:0],
//                                PC_source[1:0], Illegal
// master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mc_ctrl_if;

   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       Mem_ready;

   logic       Mem_req;
   logic       Mem_write;
   logic       IorD;
   logic       IR_write;
   logic       PC_write;
   logic       Reg_write;
   logic       Reg_dst;
   logic       Mem_to_reg;
   logic       ALU_SrcA;
   logic [2:0] ALU_SrcB;
   logic       Ex_top;
   logic [2:0] ALU_op;
   logic [1:0] PC_source;
   logic       Illegal;

   modport master (
      input  Opcode, Funct, Zero, Mem_ready,
      output Mem_req, Mem_write, IorD, IR_write, PC_write, Reg_write,
             Reg_dst, Mem_to_reg, ALU_SrcA, ALU_SrcB, Ex_top, ALU_op,
             PC_source, Illegal
   );

   modport slave (
      output Opcode, Funct, Zero, Mem_ready,
      input  Mem_req, Mem_write, IorD, IR_write, PC_write, Reg_write,
             Reg_dst, Mem_to_reg, ALU_SrcA, ALU_SrcB, Ex_top, ALU_op,
             PC_source, Illegal
   );

endinterface

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Output decoder of the multi-cycle controller. Purely combinational: outputs
// follow the state, except the FETCH write strobes (qualified by mem_ready) and
// the BRANCH PC write (qualified by zero).
//   state     in  current controller state
//   op_class  in  op-class latched in DECODE
//   illegal   in  sticky illegal-opcode flag
//   zero      in  ALU zero flag
//   mem_ready in  memory completion strobe
//   ctrl      out decoded control bundle
// -----------------------------------------------------------------------------
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_e    state,
   input  op_class_e op_class,
   input  logic      illegal,
   input  logic      zero,
   input  logic      mem_ready,
   output ctrl_t     ctrl
);

   // Control outputs decoded from state and op-class.
   always_comb begin
      ctrl         = CTRL_IDLE;
      ctrl.illegal = illegal;
      case (state)
         ST_INIT: begin
            ctrl = CTRL_IDLE;
         end
         ST_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_source = PCSRC_ALU;
            // IR and PC load only on the cycle the fetch completes
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         ST_DECODE: begin
            // speculative branch target PC + (offset << 2) into ALUOut
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRCB_OFFSET;
            ctrl.ex_top    = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.ex_top    = 1'b1;
            ctrl.alu_op    = ALU_ADD;
         end
         ST_MEM_RD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         ST_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         ST_R_EX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_FUNCT;
         end
         ST_R_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         ST_I_EX: begin
            ctrl.alu_src_a = 1'b1;
            case (op_class)
               OPC_ADDI: begin
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.ex_top    = 1'b1;
                  ctrl.alu_op    = ALU_ADD;
               end
               OPC_ANDI: begin
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.ex_top    = 1'b0;
                  ctrl.alu_op    = ALU_AND;
               end
               OPC_ORI: begin
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.ex_top    = 1'b0;
                  ctrl.alu_op    = ALU_OR;
               end
               OPC_SLTI: begin
                  ctrl.alu_src_b = SRCB_IMM;
                  ctrl.ex_top    = 1'b1;
                  ctrl.alu_op    = ALU_SLT;
               end
               OPC_LUI: begin
                  // rs field is $0 in lui, so A is zero and OR passes imm<<16
                  ctrl.alu_src_b = SRCB_UPPER;
                  ctrl.alu_op    = ALU_OR;
               end
               default: begin
                  ctrl.alu_src_b = SRCB_RT;
               end
            endcase
         end
         ST_I_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_source = PCSRC_ALUOUT;
            if (op_class == OPC_BEQ) begin
               ctrl.pc_write = zero;
            end else if (op_class == OPC_BNE) begin
               ctrl.pc_write = ~zero;
            end else begin
               ctrl.pc_write = 1'b0;
            end
         end
         ST_JUMP: begin
            ctrl.pc_source = PCSRC_JUMP;
            ctrl.pc_write  = 1'b1;
         end
         ST_HALT: begin
            ctrl.illegal = 1'b1;
         end
         default: begin
            ctrl = CTRL_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle MIPS-subset controller: state register, op-class latch, sticky
// Illegal flag and next-state logic; output decoding lives in mc_ctrl_decode.
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    master side of mc_ctrl_if (Opcode/Funct/Zero/Mem_ready in,
//          datapath and memory controls out)
// -----------------------------------------------------------------------------
module mc_control_fsm
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   mc_ctrl_if.master   bus
);

   state_e    state_r;
   state_e    state_next_s;
   op_class_e op_class_r;
   op_class_e decoded_class_s;
   logic      illegal_r;
   logic      enter_halt_s;
   ctrl_t     ctrl_s;

   // Classify the incoming opcode; only consumed while in DECODE.
   always_comb begin
      decoded_class_s = classify(bus.Opcode);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Op-class latch: captured once per instruction in DECODE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_class_r <= OPC_NONE;
      end else if (state_r == ST_DECODE) begin
         op_class_r <= decoded_class_s;
      end else begin
         op_class_r <= op_class_r;
      end
   end

   // Sticky Illegal flag, set on the DECODE->HALT transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_r <= 1'b0;
      end else if (enter_halt_s) begin
         illegal_r <= 1'b1;
      end else begin
         illegal_r <= illegal_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_INIT: begin
            state_next_s = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.Mem_ready) begin
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE: begin
            case (decoded_class_s)
               OPC_LW, OPC_SW:   state_next_s = ST_MEM_ADDR;
               OPC_RTYPE:        state_next_s = ST_R_EX;
               OPC_ADDI, OPC_ANDI, OPC_ORI, OPC_SLTI, OPC_LUI:
                                 state_next_s = ST_I_EX;
               OPC_BEQ, OPC_BNE: state_next_s = ST_BRANCH;
               OPC_JUMP:         state_next_s = ST_JUMP;
               default:          state_next_s = ST_HALT;
            endcase
         end
         ST_MEM_ADDR: begin
            if (op_class_r == OPC_LW) begin
               state_next_s = ST_MEM_RD;
            end else if (op_class_r == OPC_SW) begin
               state_next_s = ST_MEM_WR;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_MEM_RD: begin
            if (bus.Mem_ready) begin
               state_next_s = ST_MEM_WB;
            end else begin
               state_next_s = ST_MEM_RD;
            end
         end
         ST_MEM_WB: begin
            state_next_s = ST_FETCH;
         end
         ST_MEM_WR: begin
            if (bus.Mem_ready) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_MEM_WR;
            end
         end
         ST_R_EX:   state_next_s = ST_R_WB;
         ST_R_WB:   state_next_s = ST_FETCH;
         ST_I_EX:   state_next_s = ST_I_WB;
         ST_I_WB:   state_next_s = ST_FETCH;
         ST_BRANCH: state_next_s = ST_FETCH;
         ST_JUMP:   state_next_s = ST_FETCH;
         ST_HALT:   state_next_s = ST_HALT;
         default:   state_next_s = ST_INIT;
      endcase
   end

   // Halt entry qualifies the sticky Illegal flag.
   always_comb begin
      if ((state_r == ST_DECODE) && (state_next_s == ST_HALT)) begin
         enter_halt_s = 1'b1;
      end else begin
         enter_halt_s = 1'b0;
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_r),
      .op_class  (op_class_r),
      .illegal   (illegal_r),
      .zero      (bus.Zero),
      .mem_ready (bus.Mem_ready),
      .ctrl      (ctrl_s)
   );

   assign bus.Mem_req    = ctrl_s.mem_req;
   assign bus.Mem_write  = ctrl_s.mem_write;
   assign bus.IorD       = ctrl_s.iord;
   assign bus.IR_write   = ctrl_s.ir_write;
   assign bus.PC_write   = ctrl_s.pc_write;
   assign bus.Reg_write  = ctrl_s.reg_write;
   assign bus.Reg_dst    = ctrl_s.reg_dst;
   assign bus.Mem_to_reg = ctrl_s.mem_to_reg;
   assign bus.ALU_SrcA   = ctrl_s.alu_src_a;
   assign bus.ALU_SrcB   = ctrl_s.alu_src_b;
   assign bus.Ex_top     = ctrl_s.ex_top;
   assign bus.ALU_op     = ctrl_s.alu_op;
   assign bus.PC_source  = ctrl_s.pc_source;
   assign bus.Illegal    = ctrl_s.illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Self-checking bench for mc_control_fsm. A reference model expands each
// instruction into its expected per-cycle output vectors (fetch wait cycles,
// decode, class-specific phases) and the stimulus for every cycle; random
// opcodes and Mem_ready/Zero values are driven in cycles where they must be
// ignored.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_ANDI  = 6'b001100;
   localparam logic [5:0] T_ORI   = 6'b001101;
   localparam logic [5:0] T_LUI   = 6'b001111;
   localparam logic [5:0] T_SLTI  = 6'b001010;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_BNE   = 6'b000101;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] LEGAL_OPS [11] = '{T_RTYPE, T_LW, T_SW, T_ADDI, T_ANDI,
                                             T_ORI, T_LUI, T_SLTI, T_BEQ, T_BNE, T_J};
   localparam logic [18:0] ZERO_VEC = 19'd0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   mc_ctrl_if bus();

   mc_control_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // {Mem_req,Mem_write,IorD,IR_write,PC_write,Reg_write,Reg_dst,Mem_to_reg,
   //  ALU_SrcA,ALU_SrcB[3],Ex_top,ALU_op[3],PC_source[2],Illegal}
   logic [18:0] obs;
   assign obs = {bus.Mem_req, bus.Mem_write, bus.IorD, bus.IR_write, bus.PC_write,
                 bus.Reg_write, bus.Reg_dst, bus.Mem_to_reg, bus.ALU_SrcA,
                 bus.ALU_SrcB, bus.Ex_top, bus.ALU_op, bus.PC_source, bus.Illegal};

   typedef struct {
      string       tag;
      logic [5:0]  opcode;
      logic        mem_ready;
      logic        zero;
      logic [18:0] exp;
   } cyc_t;

   cyc_t q[$];

   function automatic logic [18:0] mk(input logic mreq, input logic mwr, input logic iord,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic rdst, input logic m2r, input logic srca,
                                      input logic [2:0] srcb, input logic ext,
                                      input logic [2:0] op, input logic [1:0] pcs,
                                      input logic ill);
      return {mreq, mwr, iord, irw, pcw, rw, rdst, m2r, srca, srcb, ext, op, pcs, ill};
   endfunction

   function automatic logic is_legal(input logic [5:0] opc);
      logic hit = 1'b0;
      foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == opc) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] ropc();
      return 6'($urandom);
   endfunction

   task automatic push(input string tag, input logic [5:0] opc, input logic mr,
                       input logic z, input logic [18:0] exp);
      cyc_t c;
      c.tag = tag; c.opcode = opc; c.mem_ready = mr; c.zero = z; c.exp = exp;
      q.push_back(c);
   endtask

   // Reference model: one instruction expanded into expected cycles.
   // fw/mw = number of not-ready cycles in fetch / data access;
   // zsel = 0/1 forces Zero in the branch cycle, 2 = random.
   task automatic add_instr(input logic [5:0] opc, input int fw, input int mw, input int zsel);
      logic [2:0] srcb;
      logic       ext;
      logic [2:0] op;
      logic       z;
      for (int i = 0; i <= fw; i++) begin
         logic mr = (i == fw);
         push("fetch", ropc(), mr, rbit(),
              mk(1'b1,1'b0,1'b0,mr,mr,1'b0,1'b0,1'b0,1'b0,3'd1,1'b0,3'd0,2'd0,1'b0));
      end
      push("decode", opc, rbit(), rbit(),
           mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd3,1'b1,3'd0,2'd0,1'b0));
      if (opc == T_LW || opc == T_SW) begin
         push("mem_addr", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd2,1'b1,3'd0,2'd0,1'b0));
         for (int i = 0; i <= mw; i++) begin
            if (opc == T_LW)
               push("mem_rd", ropc(), (i == mw), rbit(),
                    mk(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,2'd0,1'b0));
            else
               push("mem_wr", ropc(), (i == mw), rbit(),
                    mk(1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,2'd0,1'b0));
         end
         if (opc == T_LW)
            push("mem_wb", ropc(), rbit(), rbit(),
                 mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,3'd0,1'b0,3'd0,2'd0,1'b0));
      end else if (opc == T_RTYPE) begin
         push("r_ex", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,3'd0,1'b0,3'd2,2'd0,1'b0));
         push("r_wb", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,3'd0,1'b0,3'd0,2'd0,1'b0));
      end else if (opc == T_ADDI || opc == T_ANDI || opc == T_ORI || opc == T_SLTI || opc == T_LUI) begin
         if (opc == T_ADDI)      begin srcb = 3'd2; ext = 1'b1; op = 3'd0; end
         else if (opc == T_ANDI) begin srcb = 3'd2; ext = 1'b0; op = 3'd3; end
         else if (opc == T_ORI)  begin srcb = 3'd2; ext = 1'b0; op = 3'd4; end
         else if (opc == T_SLTI) begin srcb = 3'd2; ext = 1'b1; op = 3'd5; end
         else                    begin srcb = 3'd4; ext = 1'b0; op = 3'd4; end
         push("i_ex", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,srcb,ext,op,2'd0,1'b0));
         push("i_wb", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,2'd0,1'b0));
      end else if (opc == T_BEQ || opc == T_BNE) begin
         z = (zsel == 2) ? rbit() : 1'(zsel);
         push("branch", ropc(), rbit(), z,
              mk(1'b0,1'b0,1'b0,1'b0,(opc == T_BEQ) ? z : ~z,1'b0,1'b0,1'b0,1'b1,
                 3'd0,1'b0,3'd1,2'd1,1'b0));
      end else if (opc == T_J) begin
         push("jump", ropc(), rbit(), rbit(),
              mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,2'd2,1'b0));
      end else begin
         for (int i = 0; i < 8; i++)
            push("halt", ropc(), rbit(), rbit(),
                 mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,2'd0,1'b1));
      end
   endtask

   // Apply one queued cycle: drive at the falling edge, sample 1 ns later.
   task automatic drive_cycle(input cyc_t c, output logic [18:0] got);
      @(negedge clk);
      bus.Opcode    = c.opcode;
      bus.Funct     = 6'($urandom);
      bus.Mem_ready = c.mem_ready;
      bus.Zero      = c.zero;
      #1;
      got = obs;
   endtask

   task automatic test_reset();
      logic [18:0] got;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.Opcode = ropc(); bus.Funct = 6'($urandom);
         bus.Mem_ready = 1'b1; bus.Zero = rbit();
         #1; got = obs;
         n_cmp++;
         if (got !== ZERO_VEC) begin
            n_err++; $display("FAIL reset_held: got %h want %h", got, ZERO_VEC);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.Mem_ready = 1'b1;
      #1; got = obs;
      n_cmp++;
      if (got !== ZERO_VEC) begin
         n_err++; $display("FAIL reset_init: got %h want %h", got, ZERO_VEC);
      end
   endtask

   task automatic test_fetch_ready();
      cyc_t c; logic [18:0] got;
      add_instr(T_RTYPE, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++;
            $display("FAIL fetch_ready/%s: got %h want %h (funct %b)", c.tag, got, c.exp, bus.Funct);
         end
      end
   endtask

   task automatic test_lw_wait();
      cyc_t c; logic [18:0] got; int cycles = 0;
      add_instr(T_LW, 0, 3, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++; cycles++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL lw_wait/%s: got %h want %h", c.tag, got, c.exp);
         end
      end
      // next cycle must be a fresh fetch: 5+3 cycles for the load
      add_instr(T_J, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL lw_then_j/%s: got %h want %h after %0d cycles", c.tag, got, c.exp, cycles);
         end
      end
   endtask

   task automatic test_branch();
      cyc_t c; logic [18:0] got;
      add_instr(T_BEQ, 1, 0, 1);
      add_instr(T_BEQ, 0, 0, 0);
      add_instr(T_BNE, 0, 0, 1);
      add_instr(T_BNE, 2, 0, 0);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL branch/%s: got %h want %h (zero %b)", c.tag, got, c.exp, c.zero);
         end
      end
   endtask

   task automatic test_itype();
      cyc_t c; logic [18:0] got;
      add_instr(T_ORI, 0, 0, 2);
      add_instr(T_LUI, 1, 0, 2);
      add_instr(T_ADDI, 0, 0, 2);
      add_instr(T_ANDI, 0, 0, 2);
      add_instr(T_SLTI, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL itype/%s: got %h want %h", c.tag, got, c.exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; logic [18:0] got;
      for (int i = 0; i < 40; i++)
         add_instr(LEGAL_OPS[$urandom_range(0, 10)], $urandom_range(0, 3), $urandom_range(0, 3), 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL back_to_back/%s: got %h want %h (decode opcode %b)", c.tag, got, c.exp, c.opcode);
         end
      end
   endtask

   task automatic test_illegal(input logic [5:0] opc);
      cyc_t c; logic [18:0] got;
      add_instr(opc, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL illegal_%b/%s: got %h want %h", opc, c.tag, got, c.exp);
         end
      end
      test_reset();
      add_instr(T_ADDI, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL after_illegal/%s: got %h want %h", c.tag, got, c.exp);
         end
      end
   endtask

   task automatic test_reset_mid_wr();
      cyc_t c; logic [18:0] got;
      add_instr(T_SW, 0, 10, 2);
      while (q.size() > 5) void'(q.pop_back());   // stop two cycles into the write wait
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL mid_wr/%s: got %h want %h", c.tag, got, c.exp);
         end
      end
      @(negedge clk);
      rst_n = 1'b0; bus.Mem_ready = 1'b1;
      #1; got = obs; n_cmp++;
      if (got !== ZERO_VEC) begin
         n_err++; $display("FAIL abort_wr_async: got %h want %h", got, ZERO_VEC);
      end
      @(posedge clk); #1; got = obs; n_cmp++;
      if (got !== ZERO_VEC) begin
         n_err++; $display("FAIL abort_wr_held: got %h want %h", got, ZERO_VEC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1; got = obs; n_cmp++;
      if (got !== ZERO_VEC) begin
         n_err++; $display("FAIL abort_wr_init: got %h want %h", got, ZERO_VEC);
      end
      add_instr(T_BNE, 0, 0, 2);
      while (q.size() > 0) begin
         c = q.pop_front(); drive_cycle(c, got); n_cmp++;
         if (got !== c.exp) begin
            n_err++; $display("FAIL restart/%s: got %h want %h", c.tag, got, c.exp);
         end
      end
   endtask

   initial begin
      logic [5:0] bad;
      bus.Opcode = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.Mem_ready = 1'b0;
      #2;
      test_reset();
      test_fetch_ready();
      test_lw_wait();
      test_branch();
      test_itype();
      test_back_to_back();
      test_illegal(6'b111111);
      bad = ropc();
      while (is_legal(bad)) bad = ropc();
      test_illegal(bad);
      test_reset_mid_wr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
